// File: rtl/sign_packer.sv
// Snapshots NUM_CNT sign bits on capture and streams them out as NWORDS 32-bit words (LSW first);
// first word 1 cycle after capture; m_ready low holds the word; optional SIGN_PACKER_OVR_CNT_EN adds ovr_cnt.
module sign_packer #(
    parameter int NUM_CNT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CNT-1:0] sign_bits,
    input  logic               capture,
    output logic [31:0]        m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic               done,
`ifdef SIGN_PACKER_OVR_CNT_EN
    output logic               overrun,
    output logic [7:0]         ovr_cnt
`else
    output logic               overrun
`endif
);

    localparam int NWORDS = NUM_CNT / 32;
    localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state_q, state_d;
    logic [NWORDS-1:0][31:0]  snap_q, snap_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic                     done_q, done_d;
    logic                     overrun_q, overrun_d;
    logic                     at_last;
    logic                     drop;

    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    snap_d  = sign_bits;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (at_last) begin
                        done_d = 1'b1;
                        // A capture landing on the final transfer chains straight into a new stream.
                        if (capture) begin
                            snap_d = sign_bits;
                            idx_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                drop = capture && !(m_ready && at_last);
            end
            default: state_d = IDLE;
        endcase
        overrun_d = overrun_q | drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef SIGN_PACKER_OVR_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (drop && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
`endif

    assign m_valid = (state_q == SEND);
    assign busy    = (state_q == SEND);
    assign m_last  = (state_q == SEND) && at_last;
    assign m_data  = snap_q[idx_q];
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sign_packer.sv
// Directed bench for sign_packer: cycle table on a 64-bit instance, saturation sequence on a 32-bit one.
module tb_sign_packer;

    logic        clk = 1'b0;
    logic        rst, capture, m_ready;
    logic [63:0] sign_bits;
    logic [31:0] m_data;
    logic        m_valid, m_last, busy, done, overrun;
    logic [7:0]  ovr_cnt;

    logic        rst32, cap32, rdy32;
    logic [31:0] sb32;
    logic [31:0] dat32;
    logic        vld32, last32, busy32, done32, ovr32;
    logic [7:0]  oc32;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sign_packer #(.NUM_CNT(64)) u_dut (
        .clk(clk), .rst(rst), .sign_bits(sign_bits), .capture(capture),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done),
`ifdef SIGN_PACKER_OVR_CNT_EN
        .overrun(overrun), .ovr_cnt(ovr_cnt)
`else
        .overrun(overrun)
`endif
    );

    sign_packer #(.NUM_CNT(32)) u_dut32 (
        .clk(clk), .rst(rst32), .sign_bits(sb32), .capture(cap32),
        .m_data(dat32), .m_valid(vld32), .m_ready(rdy32), .m_last(last32),
        .busy(busy32), .done(done32),
`ifdef SIGN_PACKER_OVR_CNT_EN
        .overrun(ovr32), .ovr_cnt(oc32)
`else
        .overrun(ovr32)
`endif
    );

`ifndef SIGN_PACKER_OVR_CNT_EN
    assign ovr_cnt = 8'd0;
    assign oc32    = 8'd0;
`endif

    typedef struct {
        logic        rst;
        logic        cap;
        logic [63:0] sb;
        logic        rdy;
        logic        vld;
        logic [31:0] dat;
        logic        last;
        logic        busy;
        logic        done;
        logic        ovr;
        logic [7:0]  oc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic c, input logic [63:0] s, input logic rd,
                                input logic v, input logic [31:0] d, input logic l, input logic b,
                                input logic dn, input logic o, input logic [7:0] oc);
        vec_t t;
        t.rst = r; t.cap = c; t.sb = s; t.rdy = rd;
        t.vld = v; t.dat = d; t.last = l; t.busy = b; t.done = dn; t.ovr = o; t.oc = oc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [63:0] X = 64'hDEADBEEF_12345678;
    localparam logic [63:0] Y = 64'h00000001_80000000;
    localparam logic [63:0] F = 64'hFFFFFFFF_FFFFFFFF;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst cap sign_bits rdy | vld data last busy done ovr ovr_cnt
        vecs.push_back(mk(1, 1, X, 1,  0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, X, 1,  0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 32'h12345678, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 32'hDEADBEEF, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0,            0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0,            0, 0, 0, 0, 0));
        // stall three cycles on word 0, then one on the last word
        vecs.push_back(mk(0, 1, X, 0,  0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 32'h12345678, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 32'h12345678, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 32'h12345678, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 32'h12345678, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 32'hDEADBEEF, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 32'hDEADBEEF, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0,            0, 0, 1, 0, 0));
        // capture dropped during word 0
        vecs.push_back(mk(0, 1, X, 0,  0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, F, 0,  1, 32'h12345678, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 32'h12345678, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1,  1, 32'hDEADBEEF, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0,            0, 0, 1, 1, 1));
        // capture coincident with final transfer chains without a bubble
        vecs.push_back(mk(0, 1, X, 1,  0, 0,            0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1,  1, 32'h12345678, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, Y, 1,  1, 32'hDEADBEEF, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1,  1, 32'h80000000, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1,  1, 32'h00000001, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0,            0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0,            0, 0, 0, 1, 1));
        // reset mid-stream on the cycle the last word would transfer
        vecs.push_back(mk(0, 1, X, 1,  0, 0,            0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1,  1, 32'h12345678, 0, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1,  1, 32'hDEADBEEF, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, Y, 1,  0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 32'h80000000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 32'h80000000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 32'h00000001, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0,            0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0,            0, 0, 0, 0, 0));

        rst = 1'b1; capture = 1'b0; m_ready = 1'b0; sign_bits = '0;
        rst32 = 1'b1; cap32 = 1'b0; rdy32 = 1'b0; sb32 = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; capture = vecs[i].cap; sign_bits = vecs[i].sb; m_ready = vecs[i].rdy;
            #1;
            chk($sformatf("row%0d vld/dat/last/busy/done/ovr", i),
                {26'd0, m_valid, (m_valid ? m_data : 32'd0), m_last, busy, done, overrun},
                {26'd0, vecs[i].vld, (vecs[i].vld ? vecs[i].dat : 32'd0), vecs[i].last,
                 vecs[i].busy, vecs[i].done, vecs[i].ovr});
`ifdef SIGN_PACKER_OVR_CNT_EN
            chk($sformatf("row%0d ovr_cnt", i), {56'd0, ovr_cnt}, {56'd0, vecs[i].oc});
`endif
        end

        // single-word instance: capture, then 300 dropped captures under a held stall
        @(negedge clk);
        rst32 = 1'b0; cap32 = 1'b1; sb32 = 32'hA5A50F0F; rdy32 = 1'b0;
        @(negedge clk);
        #1;
        chk("w32 first word", {28'd0, vld32, last32, busy32, ovr32, dat32},
            {28'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA5A50F0F});
        sb32 = 32'h11112222;
        repeat (300) @(negedge clk);
        #1;
        chk("w32 stall hold", {29'd0, vld32, last32, ovr32, dat32},
            {29'd0, 1'b1, 1'b1, 1'b1, 32'hA5A50F0F});
`ifdef SIGN_PACKER_OVR_CNT_EN
        chk("w32 ovr_cnt saturate", {56'd0, oc32}, {56'd0, 8'd255});
`endif
        rdy32 = 1'b1; sb32 = 32'h13579BDF;
        @(negedge clk);
        #1;
        chk("w32 chained capture", {29'd0, vld32, done32, last32, dat32},
            {29'd0, 1'b1, 1'b1, 1'b1, 32'h13579BDF});
        cap32 = 1'b0;
        @(negedge clk);
        #1;
        chk("w32 final done", {60'd0, vld32, busy32, done32, ovr32}, {60'd0, 4'b0011});
        @(negedge clk);
        #1;
        chk("w32 done single pulse", {62'd0, done32, vld32}, 64'd0);
`ifdef SIGN_PACKER_OVR_CNT_EN
        chk("w32 ovr_cnt held", {56'd0, oc32}, {56'd0, 8'd255});
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
